// File: rtl/load_store_unit.sv
// load_store_unit: sub-word load/store unit between EX/MEM and a word-wide
// data memory. Loads are extracted, extended and registered for MEM/WB.
// Word stores write in one cycle; byte/half stores read-modify-write over
// two cycles while stalling the pipeline.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (trap misaligned half/word
// accesses instead of masking the low address bits).
//
// Handshake: a request is taken whenever req_valid=1 in IDLE and rst=0.
// If stall=1 the requester holds the same instruction for exactly one more
// cycle; that cycle's inputs are ignored (the RMW write completes it).
module load_store_unit #(
  parameter int ADR_WIDTH = 32,
  parameter int MEM_AW    = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  input  logic                 req_read,
  input  logic                 req_write,
  input  logic [1:0]           req_size,
  input  logic                 req_unsigned,
  input  logic [ADR_WIDTH-1:0] req_addr,
  input  logic [31:0]          req_wdata,
  output logic                 stall,
  output logic                 ld_valid,
  output logic [31:0]          ld_data,
  output logic                 misalign,
  output logic                 mem_re,
  output logic                 mem_we,
  output logic [MEM_AW-1:0]    mem_addr,
  output logic [31:0]          mem_wdata,
  input  logic [31:0]          mem_rdata,
  output logic                 dbg_state
);

  typedef enum logic {IDLE = 1'b0, RMW_WR = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [31:0]       merged, merged_q;
  logic [MEM_AW-1:0] rmw_addr_q;
  logic [MEM_AW-1:0] req_waddr;
  logic [7:0]        lane_b;
  logic [15:0]       lane_h;
  logic [31:0]       ld_ext;
  logic              size_word, size_half;
  logic              is_rd, is_wr, mis;
  logic              idle_ok, load_fire, wstore_fire, sstore_fire;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^req_addr[ADR_WIDTH-1:MEM_AW+2];

  assign size_word = req_size[1];
  assign size_half = (req_size == 2'b01);
  assign is_rd     = req_valid & req_read & ~req_write;
  assign is_wr     = req_valid & req_write;
  assign req_waddr = req_addr[MEM_AW+1:2];

`ifdef LSU_MISALIGN_TRAP_EN
  assign mis = (is_rd | is_wr) &
               ((size_half & req_addr[0]) | (size_word & (|req_addr[1:0])));
`else
  assign mis = 1'b0;
`endif

  assign idle_ok     = (state == IDLE) & ~rst & ~mis;
  assign load_fire   = idle_ok & is_rd;
  assign wstore_fire = idle_ok & is_wr & size_word;
  assign sstore_fire = idle_ok & is_wr & ~size_word;

  // Lane extraction and sign/zero extension of the memory word
  always_comb begin
    lane_b = mem_rdata[7:0];
    case (req_addr[1:0])
      2'd0: lane_b = mem_rdata[7:0];
      2'd1: lane_b = mem_rdata[15:8];
      2'd2: lane_b = mem_rdata[23:16];
      2'd3: lane_b = mem_rdata[31:24];
      default: lane_b = mem_rdata[7:0];
    endcase
    lane_h = req_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    if (size_word)
      ld_ext = mem_rdata;
    else if (size_half)
      ld_ext = {{16{~req_unsigned & lane_h[15]}}, lane_h};
    else
      ld_ext = {{24{~req_unsigned & lane_b[7]}}, lane_b};
  end

  // Merge store data into the word read during the first RMW cycle
  always_comb begin
    merged = mem_rdata;
    if (size_half) begin
      if (req_addr[1]) merged[31:16] = req_wdata[15:0];
      else             merged[15:0]  = req_wdata[15:0];
    end else begin
      case (req_addr[1:0])
        2'd0: merged[7:0]   = req_wdata[7:0];
        2'd1: merged[15:8]  = req_wdata[7:0];
        2'd2: merged[23:16] = req_wdata[7:0];
        2'd3: merged[31:24] = req_wdata[7:0];
        default: merged = mem_rdata;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sstore_fire) state_nxt = RMW_WR;
      RMW_WR:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Memory-side and stall outputs; rst forces all enables low
  always_comb begin
    stall     = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = req_waddr;
    mem_wdata = req_wdata;
    if (state == RMW_WR) begin
      mem_we    = ~rst;
      mem_addr  = rmw_addr_q;
      mem_wdata = merged_q;
    end else begin
      mem_re = load_fire | sstore_fire;
      mem_we = wstore_fire;
      stall  = sstore_fire;
    end
  end

  assign dbg_state = state;

  // Latch merged word and address for the RMW write cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      merged_q   <= '0;
      rmw_addr_q <= '0;
    end else if (sstore_fire) begin
      merged_q   <= merged;
      rmw_addr_q <= req_waddr;
    end
  end

  // Register load result and status pulses for MEM/WB
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_valid <= 1'b0;
      ld_data  <= '0;
    end else begin
      ld_valid <= load_fire;
      if (load_fire) ld_data <= ld_ext;
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  // One-cycle pulse for a trapped misaligned access
  always_ff @(posedge clk) begin
    if (rst) misalign <= 1'b0;
    else     misalign <= (state == IDLE) & mis;
  end
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit with a behavioural 64-word memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_read, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        stall, ld_valid, misalign, mem_re, mem_we, dbg_state;
  logic [31:0] ld_data, mem_wdata, mem_rdata;
  logic [5:0]  mem_addr;

  logic [31:0] mem [64];
  logic        pre_we;
  logic [5:0]  pre_addr;
  logic [31:0] pre_data;
  int          wr_count;
  int          n_vec;
  int          n_err;
  int          wc0;

  // Clock
  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_read(req_read), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .ld_valid(ld_valid), .ld_data(ld_data),
    .misalign(misalign), .mem_re(mem_re), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state)
  );

  // Behavioural data memory: combinational read, write on rising edge
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      wr_count <= wr_count + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_req();
    req_valid = 0; req_read = 0; req_write = 0;
    req_size = 2'b10; req_unsigned = 0; req_addr = 0; req_wdata = 0;
  endtask

  task automatic set_req(input logic rd, input logic wr, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a, input logic [31:0] d);
    req_valid = 1; req_read = rd; req_write = wr;
    req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = d;
  endtask

  task automatic preload(input logic [5:0] a, input logic [31:0] d);
    idle_req();
    pre_we = 1; pre_addr = a; pre_data = d;
    tick();
    pre_we = 0;
  endtask

  task automatic do_load(input string tag, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] exp);
    set_req(1, 0, sz, uns, a, 32'h0);
    tick();
    chk({tag, "_vld"}, {31'b0, ld_valid}, 32'd1);
    chk(tag, ld_data, exp);
    idle_req();
  endtask

  initial begin
    n_vec = 0; n_err = 0; wr_count = 0;
    pre_we = 0; pre_addr = 0; pre_data = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    idle_req();

    // Reset: enables and stall forced low even with a request present
    rst = 1;
    set_req(0, 1, 2'b00, 0, 32'h10, 32'hAB);
    #2;
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_we", {31'b0, mem_we}, 32'd0);
    chk("rst_re", {31'b0, mem_re}, 32'd0);
    tick();
    tick();
    idle_req();
    rst = 0;
    chk("rst_ldv", {31'b0, ld_valid}, 32'd0);
    chk("rst_ldd", ld_data, 32'h0);
    chk("rst_mis", {31'b0, misalign}, 32'd0);
    chk("rst_state", {31'b0, dbg_state}, 32'd0);
    tick();

    // Word store then word load
    wc0 = wr_count;
    set_req(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF);
    #1;
    chk("sw_we", {31'b0, mem_we}, 32'd1);
    chk("sw_re", {31'b0, mem_re}, 32'd0);
    chk("sw_stall", {31'b0, stall}, 32'd0);
    chk("sw_addr", {26'b0, mem_addr}, 32'd4);
    chk("sw_wdata", mem_wdata, 32'hDEADBEEF);
    tick();
    chk("sw_mem", mem[4], 32'hDEADBEEF);
    chk("sw_wcnt", wr_count - wc0, 32'd1);
    set_req(1, 0, 2'b10, 0, 32'h10, 32'h0);
    #1;
    chk("lw_re", {31'b0, mem_re}, 32'd1);
    chk("lw_we", {31'b0, mem_we}, 32'd0);
    tick();
    chk("lw_vld", {31'b0, ld_valid}, 32'd1);
    chk("lw_data", ld_data, 32'hDEADBEEF);
    idle_req();
    tick();
    chk("idle_ldv", {31'b0, ld_valid}, 32'd0);

    // Byte/half load extension
    preload(6'd4, 32'h11223344);
    do_load("lb13", 2'b00, 0, 32'h13, 32'h00000011);
    do_load("lbu13", 2'b00, 1, 32'h13, 32'h00000011);
    preload(6'd4, 32'h80FF7F01);
    do_load("lb12", 2'b00, 0, 32'h12, 32'hFFFFFFFF);
    do_load("lbu12", 2'b00, 1, 32'h12, 32'h000000FF);
    do_load("lh12", 2'b01, 0, 32'h12, 32'hFFFF80FF);
    do_load("lhu12", 2'b01, 1, 32'h12, 32'h000080FF);
    do_load("lb11", 2'b00, 0, 32'h11, 32'h0000007F);
    do_load("lh10", 2'b01, 0, 32'h10, 32'h00007F01);

    // Sub-word stores via read-modify-write
    preload(6'd4, 32'h11223344);
    wc0 = wr_count;
    set_req(0, 1, 2'b00, 0, 32'h11, 32'h000000AA);
    #1;
    chk("sb_stall", {31'b0, stall}, 32'd1);
    chk("sb_we0", {31'b0, mem_we}, 32'd0);
    chk("sb_re0", {31'b0, mem_re}, 32'd1);
    tick();
    chk("sb_state", {31'b0, dbg_state}, 32'd1);
    chk("sb_stall1", {31'b0, stall}, 32'd0);
    chk("sb_we1", {31'b0, mem_we}, 32'd1);
    chk("sb_re1", {31'b0, mem_re}, 32'd0);
    chk("sb_addr1", {26'b0, mem_addr}, 32'd4);
    chk("sb_wdata1", mem_wdata, 32'h1122AA44);
    tick();
    chk("sb_mem", mem[4], 32'h1122AA44);
    chk("sb_wcnt", wr_count - wc0, 32'd1);
    chk("sb_ldv", {31'b0, ld_valid}, 32'd0);
    set_req(0, 1, 2'b01, 0, 32'h12, 32'h1234BEEF);
    tick();
    tick();
    chk("sh_mem", mem[4], 32'hBEEFAA44);
    idle_req();

    // Sub-word store immediately followed by a load of the same word
    wc0 = wr_count;
    set_req(0, 1, 2'b00, 0, 32'h10, 32'h00000077);
    tick();
    tick();
    set_req(1, 0, 2'b10, 0, 32'h10, 32'h0);
    #1;
    chk("b2b_stall", {31'b0, stall}, 32'd0);
    chk("b2b_re", {31'b0, mem_re}, 32'd1);
    tick();
    chk("b2b_vld", {31'b0, ld_valid}, 32'd1);
    chk("b2b_data", ld_data, 32'hBEEFAA77);
    idle_req();
    tick();
    chk("b2b_wcnt", wr_count - wc0, 32'd1);

    // Reset during the RMW write cycle suppresses the write
    preload(6'd8, 32'hCAFEF00D);
    do_load("pre_rst_ld", 2'b10, 0, 32'h20, 32'hCAFEF00D);
    set_req(0, 1, 2'b00, 0, 32'h20, 32'h00000055);
    tick();
    rst = 1;
    #1;
    chk("rmwrst_we", {31'b0, mem_we}, 32'd0);
    tick();
    rst = 0;
    idle_req();
    chk("rmwrst_mem", mem[8], 32'hCAFEF00D);
    chk("rmwrst_state", {31'b0, dbg_state}, 32'd0);
    chk("rmwrst_ldv", {31'b0, ld_valid}, 32'd0);
    chk("rmwrst_ldd", ld_data, 32'h0);
    chk("rmwrst_mis", {31'b0, misalign}, 32'd0);
    chk("rmwrst_stall", {31'b0, stall}, 32'd0);

    // Misaligned word load at 0x06
    preload(6'd1, 32'h01020304);
    set_req(1, 0, 2'b10, 0, 32'h06, 32'h0);
    #1;
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis_re", {31'b0, mem_re}, 32'd0);
    chk("mis_we", {31'b0, mem_we}, 32'd0);
    chk("mis_stall", {31'b0, stall}, 32'd0);
    tick();
    idle_req();
    chk("mis_pulse", {31'b0, misalign}, 32'd1);
    chk("mis_ldv", {31'b0, ld_valid}, 32'd0);
    tick();
    chk("mis_end", {31'b0, misalign}, 32'd0);
`else
    chk("mis_re", {31'b0, mem_re}, 32'd1);
    chk("mis_addr", {26'b0, mem_addr}, 32'd1);
    tick();
    idle_req();
    chk("mis_ldv", {31'b0, ld_valid}, 32'd1);
    chk("mis_data", ld_data, 32'h01020304);
    chk("mis_flag", {31'b0, misalign}, 32'd0);
    do_load("lh13_mask", 2'b01, 0, 32'h13, 32'hFFFFBEEF);
`endif

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
